// File: rtl/wb_pkg.sv
// Shared types for the GRF writeback arbiter: entry layout and the hardwired zero register.
package wb_pkg;

    localparam int WB_AW = 5;
    localparam int WB_DW = 32;

    localparam logic [WB_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_AW-1:0] a3;
        logic [WB_DW-1:0] wd;
    } wb_entry_t;

    // True when a is a real (non-$0) register and equals b.
    function automatic logic addr_match(logic [WB_AW-1:0] a, logic [WB_AW-1:0] b);
        return (a != REG_ZERO) && (a == b);
    endfunction

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bundle of pipeline, MD, hazard-query and GRF write-port signals around grf_wb_arbiter.
interface grf_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          pipe_we;
    logic [AW-1:0] pipe_a3;
    logic [DW-1:0] pipe_wd;
    logic          md_valid;
    logic [AW-1:0] md_a3;
    logic [DW-1:0] md_wd;
    logic          md_ready;
    logic [AW-1:0] q_a1;
    logic [AW-1:0] q_a2;
    logic          q_hit1;
    logic          q_hit2;
    logic          grf_we;
    logic [AW-1:0] grf_a3;
    logic [DW-1:0] grf_wd;

    // Environment side: pipeline, MD unit, hazard unit, GRF.
    modport master (
        output pipe_we, pipe_a3, pipe_wd,
        output md_valid, md_a3, md_wd,
        input  md_ready,
        output q_a1, q_a2,
        input  q_hit1, q_hit2,
        input  grf_we, grf_a3, grf_wd
    );

    modport slave (
        input  pipe_we, pipe_a3, pipe_wd,
        input  md_valid, md_a3, md_wd,
        output md_ready,
        input  q_a1, q_a2,
        output q_hit1, q_hit2,
        output grf_we, grf_a3, grf_wd
    );
endinterface

// File: rtl/wb_fifo.sv
// In-order MD result buffer; exposes every slot and its valid bit for the pending-write search.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  wb_entry_t              i_push_data,
    input  logic                   i_pop,
    output wb_entry_t              o_head,
    output logic                   o_empty,
    output logic                   o_full,
    output wb_entry_t              o_entries [DEPTH],
    output logic [DEPTH-1:0]       o_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_FULL);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // NOTE: the data array carries no reset; r_valid alone says which slots mean anything.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: every register in a clocked block uses <= so all of them see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // A push and a pop in one cycle always touch different slots (never both when full/empty).
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_valid   = r_valid;

endmodule

// File: rtl/grf_wb_arbiter.sv
// Merges pipeline WB and buffered mult/div results onto the single GRF write port.
// Optional: define WB_TRACE_EN for a simulation-only trace of each GRF write.
module grf_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic              clk,
    input  logic              rst,
    grf_wb_arbiter_if.slave   io_wb
);

    logic          r_alive;
    logic          r_grf_we;
    logic [AW-1:0] r_grf_a3;
    logic [DW-1:0] r_grf_wd;

    wb_entry_t        w_md_entry;
    wb_entry_t        w_head;
    wb_entry_t        w_entries [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic             w_empty;
    logic             w_full;
    logic             w_md_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_pipe_req;
    logic             w_hit1;
    logic             w_hit2;

    // Holds md_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_alive <= 1'b0;
        else     r_alive <= 1'b1;
    end

    // Depends only on registered state, so a pop never ripples into md_ready.
    assign w_md_ready = r_alive & ~w_full;

    // A $0 destination completes the handshake but is never stored.
    assign w_md_entry = '{a3: io_wb.md_a3, wd: io_wb.md_wd};
    assign w_push     = io_wb.md_valid & w_md_ready & (io_wb.md_a3 != REG_ZERO);
    assign w_pipe_req = io_wb.pipe_we & (io_wb.pipe_a3 != REG_ZERO);
    assign w_pop      = ~w_pipe_req & ~w_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_md_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_entries   (w_entries),
        .o_valid     (w_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grf_we <= 1'b0;
            r_grf_a3 <= '0;
            r_grf_wd <= '0;
        end else if (w_pipe_req) begin
            r_grf_we <= 1'b1;
            r_grf_a3 <= io_wb.pipe_a3;
            r_grf_wd <= io_wb.pipe_wd;
        end else if (w_pop) begin
            r_grf_we <= 1'b1;
            r_grf_a3 <= w_head.a3;
            r_grf_wd <= w_head.wd;
        end else begin
            r_grf_we <= 1'b0;
        end
    end

    // A write is pending while it sits in the FIFO or in the output register.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a value unassigned.
        w_hit1 = r_grf_we & addr_match(io_wb.q_a1, r_grf_a3);
        w_hit2 = r_grf_we & addr_match(io_wb.q_a2, r_grf_a3);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && addr_match(io_wb.q_a1, w_entries[i].a3)) w_hit1 = 1'b1;
            if (w_valid[i] && addr_match(io_wb.q_a2, w_entries[i].a3)) w_hit2 = 1'b1;
        end
    end

    assign io_wb.md_ready = w_md_ready;
    assign io_wb.q_hit1   = w_hit1;
    assign io_wb.q_hit2   = w_hit2;
    assign io_wb.grf_we   = r_grf_we;
    assign io_wb.grf_a3   = r_grf_a3;
    assign io_wb.grf_wd   = r_grf_wd;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (r_grf_we) $display("%d@: $%d <= %h", $time, r_grf_a3, r_grf_wd);
    end
`else
`endif

endmodule
